// File: rtl/cdr_loop_filter.sv
// CDR digital loop filter: majority-vote decimation of bang-bang early/late
// votes feeding a proportional-plus-integral loop with a lock/gain-switch FSM.
module cdr_loop_filter #(
  parameter int VOTE_LEN    = 8,
  parameter int KP_ACQ      = 4,
  parameter int KP_TRK      = 1,
  parameter int KI_SHIFT    = 6,
  parameter int FREQ_W      = 16,
  parameter int LOCK_WINDOW = 64,
  parameter int LOCK_THRESH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     valid,
  input  logic                     up,
  input  logic                     dn,
  output logic [8:0]               phase_shift,
  output logic                     phase_valid,
  output logic signed [FREQ_W-1:0] freq_word,
  output logic                     locked
);

  localparam int PH_W = 9 + KI_SHIFT;
  localparam int VS_W = $clog2(VOTE_LEN + 1) + 1;
  localparam int VC_W = $clog2(VOTE_LEN);
  localparam int LS_W = $clog2(LOCK_WINDOW + 1) + 1;
  localparam int LC_W = (LOCK_WINDOW > 1) ? $clog2(LOCK_WINDOW) : 1;

  localparam logic signed [FREQ_W:0] FREQ_MAX = (FREQ_W + 1)'((2 ** (FREQ_W - 1)) - 1);
  localparam logic signed [FREQ_W:0] FREQ_MIN = -FREQ_MAX;
  localparam logic [PH_W-1:0]        STEP_ACQ = PH_W'(KP_ACQ << KI_SHIFT);
  localparam logic [PH_W-1:0]        STEP_TRK = PH_W'(KP_TRK << KI_SHIFT);

  typedef enum logic {
    S_ACQ   = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic signed [VS_W-1:0]   r_vote_sum;
  logic [VC_W-1:0]          r_vote_cnt;
  logic                     r_d_valid;
  logic signed [1:0]        r_d;
  logic signed [FREQ_W-1:0] r_freq_acc;
  logic [PH_W-1:0]          r_phase_acc;
  logic                     r_phase_valid;
  logic signed [LS_W-1:0]   r_lock_sum;
  logic [LC_W-1:0]          r_lock_cnt;

  logic                     w_accept;
  logic                     w_win_done;
  logic                     w_update;
  logic signed [1:0]        w_vote;
  logic signed [VS_W-1:0]   w_vote_total;
  logic signed [1:0]        w_d_new;
  logic signed [FREQ_W:0]   w_freq_ext;
  logic signed [FREQ_W-1:0] w_freq_next;
  logic [PH_W-1:0]          w_step;
  logic [PH_W-1:0]          w_prop;
  logic [PH_W-1:0]          w_freq_sext;
  logic [PH_W-1:0]          w_phase_next;
  logic signed [LS_W-1:0]   w_lock_total;
  logic [31:0]              w_lock_mag;
  logic                     w_lock_done;

  // ---------------- vote decimation ----------------
  assign w_accept     = en & valid;
  assign w_win_done   = w_accept && (r_vote_cnt == VC_W'(VOTE_LEN - 1));
  assign w_update     = en & r_d_valid;
  assign w_vote       = (up & ~dn) ? 2'sd1 : ((dn & ~up) ? -2'sd1 : 2'sd0);
  assign w_vote_total = r_vote_sum + VS_W'(w_vote);
  assign w_d_new      = (w_vote_total > 0) ? 2'sd1 : ((w_vote_total < 0) ? -2'sd1 : 2'sd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vote_sum <= '0;
      r_vote_cnt <= '0;
      r_d_valid  <= 1'b0;
      r_d        <= 2'sd0;
    end else if (en) begin
      // A pending decision is consumed by the update at this same edge.
      r_d_valid <= w_win_done;
      if (w_win_done) begin
        r_d        <= w_d_new;
        r_vote_sum <= '0;
        r_vote_cnt <= '0;
      end else if (w_accept) begin
        r_vote_sum <= w_vote_total;
        r_vote_cnt <= r_vote_cnt + 1'b1;
      end
    end
  end

  // ---------------- PI loop datapath ----------------
  assign w_freq_ext  = {r_freq_acc[FREQ_W-1], r_freq_acc} + (FREQ_W + 1)'(r_d);
  assign w_freq_next = (w_freq_ext > FREQ_MAX) ? FREQ_MAX[FREQ_W-1:0] :
                       (w_freq_ext < FREQ_MIN) ? FREQ_MIN[FREQ_W-1:0] :
                                                 w_freq_ext[FREQ_W-1:0];
  assign w_step       = (r_state == S_TRACK) ? STEP_TRK : STEP_ACQ;
  assign w_prop       = (r_d == 2'sd1) ? w_step : ((r_d == -2'sd1) ? -w_step : '0);
  // Sign-extend (or wrap) the frequency into the phase accumulator width.
  assign w_freq_sext  = PH_W'(w_freq_next);
  assign w_phase_next = r_phase_acc + w_prop + w_freq_sext;

  assign w_lock_total = r_lock_sum + LS_W'(r_d);
  assign w_lock_mag   = (w_lock_total < 0) ? 32'(-w_lock_total) : 32'(w_lock_total);
  assign w_lock_done  = (r_lock_cnt == LC_W'(LOCK_WINDOW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq_acc    <= '0;
      r_phase_acc   <= '0;
      r_phase_valid <= 1'b0;
      r_lock_sum    <= '0;
      r_lock_cnt    <= '0;
    end else begin
      r_phase_valid <= w_update;
      if (w_update) begin
        r_freq_acc  <= w_freq_next;
        r_phase_acc <= w_phase_next;
        if (w_lock_done) begin
          r_lock_sum <= '0;
          r_lock_cnt <= '0;
        end else begin
          r_lock_sum <= w_lock_total;
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- lock FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ACQ;
    else        r_state <= w_state_next;
  end

  // NOTE: the default assignment first keeps this block purely combinational
  // (no latch) on paths that do not change state.
  always_comb begin
    w_state_next = r_state;
    if (w_update && w_lock_done) begin
      case (r_state)
        S_ACQ:   if (w_lock_mag <= 32'(LOCK_THRESH))     w_state_next = S_TRACK;
        S_TRACK: if (w_lock_mag >  32'(2 * LOCK_THRESH)) w_state_next = S_ACQ;
        default: w_state_next = S_ACQ;
      endcase
    end
  end

  assign phase_shift = r_phase_acc[8+KI_SHIFT:KI_SHIFT];
  assign phase_valid = r_phase_valid;
  assign freq_word   = r_freq_acc;
  assign locked      = (r_state == S_TRACK);

endmodule

// File: tb/tb_cdr_loop_filter.sv
// Directed bench for cdr_loop_filter: default instance plus a FREQ_W=4
// instance sharing the same stimulus for the saturation case.
module tb_cdr_loop_filter;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              valid = 1'b0;
  logic              up = 1'b0;
  logic              dn = 1'b0;
  logic [8:0]        phase_shift;
  logic              phase_valid;
  logic signed [15:0] freq_word;
  logic              locked;
  logic [8:0]        s_phase_shift;
  logic              s_phase_valid;
  logic signed [3:0] s_freq_word;
  logic              s_locked;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdr_loop_filter u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .valid(valid), .up(up), .dn(dn),
    .phase_shift(phase_shift), .phase_valid(phase_valid),
    .freq_word(freq_word), .locked(locked)
  );

  cdr_loop_filter #(.FREQ_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .valid(valid), .up(up), .dn(dn),
    .phase_shift(s_phase_shift), .phase_valid(s_phase_valid),
    .freq_word(s_freq_word), .locked(s_locked)
  );

  task automatic reset_dut();
    en = 1'b1; valid = 1'b0; up = 1'b0; dn = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (phase_shift !== 9'd0 || phase_valid !== 1'b0 || freq_word !== 16'sd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: shift=%0d pv=%b freq=%0d locked=%b, want 0/0/0/0",
               phase_shift, phase_valid, freq_word, locked);
    end
    reset_dut();
    @(negedge clk);
    checks++;
    if (phase_shift !== 9'd0 || phase_valid !== 1'b0 || freq_word !== 16'sd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: shift=%0d pv=%b freq=%0d locked=%b, want 0/0/0/0",
               phase_shift, phase_valid, freq_word, locked);
    end
  endtask

  // Constant up, back-to-back windows: first/second decision, wrap, saturation.
  task automatic test_const_up();
    int k = 0;
    int first_at = -1;
    logic [14:0] acc;
    reset_dut();
    for (int i = 0; i < 106 * 8 + 2; i++) begin
      @(negedge clk);
      if (phase_valid) begin
        k++;
        if (k == 1) first_at = i;
        acc = 15'(256 * k + (k * (k + 1)) / 2);
        checks++;
        if (phase_shift !== acc[14:6]) begin
          errors++;
          $display("FAIL up_shift: decision %0d got %0d want %0d", k, phase_shift, acc[14:6]);
        end
        checks++;
        if (int'(freq_word) !== k) begin
          errors++;
          $display("FAIL up_freq: decision %0d got %0d want %0d", k, freq_word, k);
        end
        checks++;
        if (int'(s_freq_word) !== ((k < 7) ? k : 7)) begin
          errors++;
          $display("FAIL sat_freq: decision %0d got %0d want %0d", k, s_freq_word, (k < 7) ? k : 7);
        end
      end
      valid = (i < 106 * 8);
      up = 1'b1;
      dn = 1'b0;
    end
    valid = 1'b0;
    checks++;
    if (first_at !== 9) begin
      errors++;
      $display("FAIL first_latency: first pulse at cycle %0d want 9", first_at);
    end
    checks++;
    if (k !== 106) begin
      errors++;
      $display("FAIL up_pulse_count: got %0d want 106", k);
    end
    checks++;
    if (phase_shift !== 9'd0) begin
      errors++;
      $display("FAIL up_wrap: shift got %0d want 0", phase_shift);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL up_locked: got %b want 0", locked);
    end
  endtask

  // Zero decisions lock the loop; constant dn in TRACK then unlocks it.
  task automatic test_lock();
    int k = 0;
    int j;
    logic [14:0] acc;
    reset_dut();
    for (int i = 0; i < 64 * 8 + 2; i++) begin
      @(negedge clk);
      if (phase_valid) begin
        k++;
        checks++;
        if (phase_shift !== 9'd0 || freq_word !== 16'sd0) begin
          errors++;
          $display("FAIL zero_hold: decision %0d shift=%0d freq=%0d want 0/0", k, phase_shift, freq_word);
        end
        checks++;
        if (locked !== (k == 64)) begin
          errors++;
          $display("FAIL lock_acq: decision %0d locked=%b want %b", k, locked, k == 64);
        end
      end
      j = i % 8;
      valid = (i < 64 * 8);
      if (((i / 8) % 2) == 0) begin
        up = (j % 2 == 0);
        dn = (j % 2 == 1);
      end else begin
        up = 1'b1;
        dn = 1'b1;
      end
    end
    checks++;
    if (k !== 64 || locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_reached: decisions=%0d locked=%b want 64/1", k, locked);
    end
    k = 0;
    for (int i = 0; i < 64 * 8 + 2; i++) begin
      @(negedge clk);
      if (phase_valid) begin
        k++;
        acc = 15'(-(64 * k + (k * (k + 1)) / 2));
        if (k == 1) begin
          checks++;
          if (phase_shift !== 9'd510) begin
            errors++;
            $display("FAIL track_step_wrap: shift got %0d want 510", phase_shift);
          end
        end
        checks++;
        if (phase_shift !== acc[14:6] || int'(freq_word) !== -k) begin
          errors++;
          $display("FAIL dn_track: decision %0d shift=%0d freq=%0d want %0d/%0d",
                   k, phase_shift, freq_word, acc[14:6], -k);
        end
        checks++;
        if (locked !== (k < 64)) begin
          errors++;
          $display("FAIL unlock: decision %0d locked=%b want %b", k, locked, k < 64);
        end
      end
      valid = (i < 64 * 8);
      up = 1'b0;
      dn = 1'b1;
    end
    valid = 1'b0;
    checks++;
    if (k !== 64 || locked !== 1'b0) begin
      errors++;
      $display("FAIL unlock_final: decisions=%0d locked=%b want 64/0", k, locked);
    end
  endtask

  // en=0 freezes a partial window and also a pending decision.
  task automatic test_enable_freeze();
    int bad = 0;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = 1'b1; up = 1'b1; dn = 1'b0;
    end
    @(negedge clk);
    en = 1'b0; up = 1'b0; dn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (phase_valid !== 1'b0 || phase_shift !== 9'd0 || freq_word !== 16'sd0) bad++;
    end
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; valid = 1'b1; up = 1'b1; dn = 1'b0;
      @(negedge clk);
      if (phase_valid !== 1'b0) bad++;
    end
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (phase_valid !== 1'b0 || phase_shift !== 9'd0 || freq_word !== 16'sd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL en_freeze: %0d frozen cycles changed state, want 0", bad);
    end
    en = 1'b1; valid = 1'b0;
    @(negedge clk);
    checks++;
    if (phase_valid !== 1'b1 || phase_shift !== 9'd4 || int'(freq_word) !== 1) begin
      errors++;
      $display("FAIL en_resume: pv=%b shift=%0d freq=%0d want 1/4/1", phase_valid, phase_shift, freq_word);
    end
    @(negedge clk);
    checks++;
    if (phase_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_pulse_width: pv=%b want 0", phase_valid);
    end
  endtask

  // Asynchronous reset mid-window clears outputs at once and drops the partial window.
  task automatic test_reset_midwindow();
    int pulses = 0;
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid = (i < 8); up = 1'b1; dn = 1'b0;
    end
    checks++;
    if (phase_shift !== 9'd4 || int'(freq_word) !== 1) begin
      errors++;
      $display("FAIL pre_reset: shift=%0d freq=%0d want 4/1", phase_shift, freq_word);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (phase_shift !== 9'd0 || phase_valid !== 1'b0 || freq_word !== 16'sd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: shift=%0d pv=%b freq=%0d locked=%b want 0/0/0/0",
               phase_shift, phase_valid, freq_word, locked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (phase_valid) begin
        pulses++;
        checks++;
        if (i !== 9 || phase_shift !== 9'd4 || int'(freq_word) !== 1) begin
          errors++;
          $display("FAIL post_reset_window: pulse at %0d shift=%0d freq=%0d want 9/4/1",
                   i, phase_shift, freq_word);
        end
      end
      valid = (i < 8); up = 1'b1; dn = 1'b0;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL post_reset_pulses: got %0d want 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_const_up();
    test_lock();
    test_enable_freeze();
    test_reset_midwindow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
